cdc_pulse_arbiter: RTL and testbench
====================================

Name: cdc_pulse_arbiter

Overview:
- Source-domain scheduler that shares one pulse clock-domain-crossing channel between NREQ requesters.
- Each requester posts single-cycle event pulses. The block counts them per requester and issues at most one pulse per cycle to the crossing channel's write side (sigin), and only while that channel reports not full.
- For every issued pulse it presents the requester index so a companion tag path can carry it.
- Sits in the clkin domain, directly in front of the crossing channel's write counter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNT_W, 3, width of each per-requester pending-event counter; saturates at 2^CNT_W-1.
- ID_W, 2, width of grant index; must satisfy 2^ID_W >= NREQ.

Ports:
- clkin  input  1  source-domain clock; all logic on rising edge.
- clr_in  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester event pulse; each cycle high = one event.
- cdc_full  input  1  full flag from the crossing channel write counter.
- sigin  output  1  one-cycle pulse to the crossing channel (one event).
- grant_id  output  ID_W  requester index of the current sigin pulse; valid only while sigin=1.
- pending  output  NREQ  bit i = counter i nonzero.
- ovf  output  NREQ  sticky per-requester overflow (event lost at saturation).
- ovf_clr  input  1  synchronous clear of all ovf bits.
- busy  output  1  any counter nonzero or FSM not in IDLE.

Behaviour:
- Reset (clr_in=1, async): all counters=0, rr_ptr=0, FSM=IDLE, sigin=0, grant_id=0, pending=0, ovf=0, busy=0. Reset mid-operation discards all pending events; no partial pulse after release.
- Counter i, per cycle:
  - +1 if req[i] is high.
  - -1 if requester i is granted this cycle.
  - Both at once: value unchanged.
  - req[i] while the counter is at max and i is not granted: counter holds, ovf[i] set.
  - ovf_clr has lower priority than a same-cycle set.
- Grant decision is combinational on registered counters and cdc_full. sigin and grant_id are registered, so latency from req to sigin is 2 cycles minimum: counter update, then grant register.
- Round-robin arbitration: search starts at rr_ptr and wraps modulo NREQ. The first requester with a nonzero counter wins. After a grant, rr_ptr = winner+1 (wrap NREQ-1 -> 0).
- FSM states:
  - IDLE: no pending events. Go to ISSUE when any counter is nonzero.
  - ISSUE: when cdc_full=0, grant one requester (sigin=1 next cycle). Stay in ISSUE while events remain. Go to IDLE when all counters will be zero. When cdc_full=1, go to STALL with no grant.
  - STALL: no grant. Return to ISSUE on the first cycle cdc_full=0. The grant is issued that same cycle.
- Back-to-back grants are permitted every cycle while cdc_full=0.
- cdc_full is sampled in the grant cycle only. A pulse already registered is never withdrawn.
- Counters are only decremented at grant, so no event is lost while the channel is full (except through saturation, which sets ovf).
- grant_id holds its last value while sigin=0.

Optional Feature:
- Macro CDC_ARB_PRIO_EN.
- Defined: requester 0 has fixed highest priority. Whenever counter 0 is nonzero it wins. The remaining requesters share round-robin among themselves, and rr_ptr skips 0.
- Undefined: pure round-robin over all NREQ as described above.

Test Plan:
- Reset then idle: clr_in pulse with req=0 -> sigin=0, busy=0, pending=0 throughout 20 cycles.
- Single event: req=4'b0100 for 1 cycle, cdc_full=0 -> sigin=1 with grant_id=2 exactly 2 cycles later; counter back to 0; FSM returns to IDLE.
- Round robin: req=4'b1111 for 1 cycle -> four consecutive sigin pulses with grant_id 0,1,2,3.
- Full stall: 3 events on req[1], cdc_full=1 for 10 cycles -> no sigin, pending[1]=1. Release cdc_full -> 3 pulses with grant_id=1 on 3 consecutive cycles.
- Saturation: cdc_full=1, req[3] for 9 cycles -> counter 7, ovf[3]=1. Release -> exactly 7 pulses. ovf_clr -> ovf=0.
- Priority (CDC_ARB_PRIO_EN): counters 2 events on req0 and 1 on req1 -> grant_id 0,0,1. Without the macro -> 0,1,0.

Source files
------------

// File: rtl/cdc_pulse_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdc_pulse_arbiter : round-robin scheduler sharing one pulse CDC channel.
// Option CDC_ARB_PRIO_EN gives requester 0 fixed top priority.  Rev 1.0
// ---------------------------------------------------------------------------
module cdc_pulse_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 3,
  parameter int ID_W  = 2
) (
  input  logic            clkin,
  input  logic            clr_in,
  input  logic [NREQ-1:0] req,
  input  logic            cdc_full,
  output logic            sigin,
  output logic [ID_W-1:0] grant_id,
  output logic [NREQ-1:0] pending,
  output logic [NREQ-1:0] ovf,
  input  logic            ovf_clr,
  output logic            busy
);

`ifdef CDC_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam logic [1:0]       IDLE    = 2'd0;
  localparam logic [1:0]       ISSUE   = 2'd1;
  localparam logic [1:0]       STALL   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W:0]    NREQ_X  = (ID_W+1)'(NREQ);

  logic [CNT_W-1:0] cnt     [NREQ];
  logic [CNT_W-1:0] cnt_nxt [NREQ];
  logic [NREQ-1:0]  ovf_nxt;
  logic [NREQ-1:0]  dec_vec;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_ptr_nxt;
  logic [ID_W-1:0]  win;
  logic [ID_W:0]    idx;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             found;
  logic             grant;
  logic             any_nz;
  logic             any_nz_nxt;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      pending[i] = (cnt[i] != '0);
    end
  end

  assign any_nz = |pending;
  assign busy   = any_nz || (state != IDLE);

  // Scan starts at rr_ptr and wraps; in priority mode slot 0 is handled up front.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    if (PRIO_EN && pending[0]) begin
      found = 1'b1;
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= NREQ_X) begin
        idx = idx - NREQ_X;
      end
      if (!found && pending[idx[ID_W-1:0]] && !(PRIO_EN && (idx == '0))) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  assign grant = found && !cdc_full;

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant && !(PRIO_EN && (win == '0))) begin
      if (win == ID_W'(NREQ-1)) begin
        rr_ptr_nxt = PRIO_EN ? ID_W'(1) : '0;
      end else begin
        rr_ptr_nxt = win + ID_W'(1);
      end
    end
  end

  always_comb begin
    dec_vec = '0;
    if (grant) begin
      dec_vec[win] = 1'b1;
    end
  end

  // A same-cycle event and grant cancel; an event at saturation is lost and flagged.
  always_comb begin
    any_nz_nxt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cnt_nxt[i] = cnt[i];
      ovf_nxt[i] = ovf[i] & ~ovf_clr;
      if (req[i] && !dec_vec[i]) begin
        if (cnt[i] == CNT_MAX) begin
          ovf_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end else if (!req[i] && dec_vec[i]) begin
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      end
      any_nz_nxt = any_nz_nxt | (cnt_nxt[i] != '0);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_nz) begin
          state_nxt = cdc_full ? STALL : (any_nz_nxt ? ISSUE : IDLE);
        end
      end
      ISSUE: begin
        if (!any_nz) begin
          state_nxt = IDLE;
        end else if (cdc_full) begin
          state_nxt = STALL;
        end else if (!any_nz_nxt) begin
          state_nxt = IDLE;
        end
      end
      STALL: begin
        if (!cdc_full) begin
          state_nxt = any_nz_nxt ? ISSUE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge clr_in) begin
    if (clr_in) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= '0;
      end
      ovf      <= '0;
      rr_ptr   <= '0;
      state    <= IDLE;
      sigin    <= 1'b0;
      grant_id <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      ovf    <= ovf_nxt;
      rr_ptr <= rr_ptr_nxt;
      state  <= state_nxt;
      sigin  <= grant;
      if (grant) begin
        grant_id <= win;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_pulse_arbiter.sv
`default_nettype none
// tb_cdc_pulse_arbiter: vector table, directed corner sequences and a
// randomized run against an event-count reference model.
module tb_cdc_pulse_arbiter;
  localparam int NREQ = 4;
  localparam int CNT_W = 3;
  localparam int ID_W = 2;
  localparam int CMAX = 7;
`ifdef CDC_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            clkin = 1'b0;
  logic            clr_in;
  logic [NREQ-1:0] req;
  logic            cdc_full;
  logic            ovf_clr;
  logic            sigin;
  logic [ID_W-1:0] grant_id;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] ovf;
  logic            busy;

  int total = 0;
  int bad = 0;

  // reference model: pending event count per requester plus arbitration pointer
  int            m_cnt[NREQ];
  int            m_ptr;
  bit            m_sig;
  int            m_gid;
  bit [NREQ-1:0] m_ovf;

  typedef struct {
    bit         rst_before;
    logic [3:0] r;
    logic [3:0] e_pend;
    bit         e_sig;
    int         e_gid;
  } vec_t;
  vec_t tbl[9];

  cdc_pulse_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clkin   (clkin),
    .clr_in  (clr_in),
    .req     (req),
    .cdc_full(cdc_full),
    .sigin   (sigin),
    .grant_id(grant_id),
    .pending (pending),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .busy    (busy)
  );

  always #5 clkin = ~clkin;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pend();
    int v = 0;
    for (int i = 0; i < NREQ; i++) if (m_cnt[i] > 0) v |= (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    m_ptr = 0;
    m_sig = 0;
    m_gid = 0;
    m_ovf = '0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input bit full, input bit oc);
    int w = -1;
    if (!full) begin
      if (PRIO && m_cnt[0] > 0) w = 0;
      else begin
        for (int k = 0; k < NREQ; k++) begin
          int j = (m_ptr + k) % NREQ;
          if (w < 0 && m_cnt[j] > 0 && !(PRIO && j == 0)) w = j;
        end
      end
    end
    if (w >= 0 && !(PRIO && w == 0)) begin
      m_ptr = (w + 1) % NREQ;
      if (PRIO && m_ptr == 0) m_ptr = 1;
    end
    for (int i = 0; i < NREQ; i++) begin
      bit inc = r[i];
      bit dec = (w == i);
      bit lost = 0;
      if (inc && !dec) begin
        if (m_cnt[i] == CMAX) lost = 1;
        else m_cnt[i]++;
      end else if (dec && !inc) begin
        m_cnt[i]--;
      end
      m_ovf[i] = lost | (m_ovf[i] & ~oc);
    end
    m_sig = (w >= 0);
    if (w >= 0) m_gid = w;
  endtask

  task automatic check_model();
    chk("sigin", int'(sigin), int'(m_sig));
    chk("grant_id", int'(grant_id), m_gid);
    chk("pending", int'(pending), model_pend());
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("busy", int'(busy), int'(model_pend() != 0));
  endtask

  // inputs change at a falling edge; results are checked at the next falling edge
  task automatic tick(input logic [NREQ-1:0] r, input bit full, input bit oc);
    req = r;
    cdc_full = full;
    ovf_clr = oc;
    model_step(r, full, oc);
    @(negedge clkin);
    check_model();
  endtask

  task automatic do_reset();
    req = '0;
    cdc_full = 1'b0;
    ovf_clr = 1'b0;
    clr_in = 1'b1;
    model_reset();
    #1;
    check_model();
    @(negedge clkin);
    clr_in = 1'b0;
  endtask

  initial begin
    int n;
    int exp_ids[3];
    bit full_phase = 0;

    tbl[0] = '{1, 4'b0100, 4'b0100, 0, 0};
    tbl[1] = '{0, 4'b0000, 4'b0000, 1, 2};
    tbl[2] = '{0, 4'b0000, 4'b0000, 0, 2};
    tbl[3] = '{1, 4'b1111, 4'b1111, 0, 0};
    tbl[4] = '{0, 4'b0000, 4'b1110, 1, 0};
    tbl[5] = '{0, 4'b0000, 4'b1100, 1, 1};
    tbl[6] = '{0, 4'b0000, 4'b1000, 1, 2};
    tbl[7] = '{0, 4'b0000, 4'b0000, 1, 3};
    tbl[8] = '{0, 4'b0000, 4'b0000, 0, 3};

    clr_in = 1'b1;
    req = '0;
    cdc_full = 1'b0;
    ovf_clr = 1'b0;
    model_reset();
    @(negedge clkin);
    check_model();
    chk("rst_sigin", int'(sigin), 0);
    chk("rst_busy", int'(busy), 0);
    clr_in = 1'b0;

    for (int c = 0; c < 20; c++) begin
      tick('0, 0, 0);
      chk("idle_sigin", int'(sigin), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_pending", int'(pending), 0);
    end

    for (int k = 0; k < 9; k++) begin
      if (tbl[k].rst_before) do_reset();
      tick(tbl[k].r, 0, 0);
      chk($sformatf("tbl%0d_sigin", k), int'(sigin), int'(tbl[k].e_sig));
      chk($sformatf("tbl%0d_gid", k), int'(grant_id), tbl[k].e_gid);
      chk($sformatf("tbl%0d_pend", k), int'(pending), int'(tbl[k].e_pend));
    end

    do_reset();
    for (int c = 0; c < 3; c++) tick(4'b0010, 1, 0);
    for (int c = 0; c < 10; c++) begin
      tick('0, 1, 0);
      chk("stall_sigin", int'(sigin), 0);
      chk("stall_pend1", int'(pending[1]), 1);
    end
    for (int c = 0; c < 3; c++) begin
      tick('0, 0, 0);
      chk("stall_rel_sigin", int'(sigin), 1);
      chk("stall_rel_gid", int'(grant_id), 1);
    end
    tick('0, 0, 0);
    chk("stall_done_sigin", int'(sigin), 0);

    do_reset();
    for (int c = 0; c < 9; c++) tick(4'b1000, 1, 0);
    chk("sat_ovf3", int'(ovf[3]), 1);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick('0, 0, 0);
      if (sigin) n++;
    end
    chk("sat_pulses", n, 7);
    chk("sat_ovf_held", int'(ovf), 4'b1000);
    tick('0, 0, 1);
    chk("sat_ovf_clr", int'(ovf), 0);

    do_reset();
    tick(4'b0001, 1, 0);
    tick(4'b0001, 1, 0);
    tick(4'b0010, 1, 0);
    if (PRIO) exp_ids = '{0, 0, 1};
    else exp_ids = '{0, 1, 0};
    for (int k = 0; k < 3; k++) begin
      tick('0, 0, 0);
      chk($sformatf("prio_sig%0d", k), int'(sigin), 1);
      chk($sformatf("prio_gid%0d", k), int'(grant_id), exp_ids[k]);
    end

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [NREQ-1:0] r;
      bit f;
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 15) == 0) full_phase = ~full_phase;
      f = full_phase ? 1'b1 : ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
      tick(r, f, $urandom_range(0, 31) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
